chip8_program_loader: RTL and testbench

- Initiator that fills CHIP-8 main memory (4096x8) on a flash request.
- Copies the 80-byte hex font into 0x050–0x09F, then copies the selected program from the program library ROM into 0x200 onward.
- Drives the write side of the chip8 memory port while the processor is held off (busy_out); reads the library through a 2-cycle-latency BRAM read port.

---
 rtl/chip8_program_loader.sv | 172 +++++++++++++++++
 tb/tb_chip8_program_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_program_loader.sv
// CHIP-8 program loader: on a flash request, copies the hex font and then the selected program
// from the library ROM into chip8 main memory while holding the processor off.
module chip8_program_loader #(
  parameter int unsigned NUM_PROGS  = 8,
  parameter int unsigned PROG_SEL_W = 3,
  parameter int unsigned LIB_ADDR_W = 16,
  parameter int unsigned SLOT_SIZE  = 4096,
  parameter logic [11:0] FONT_DEST  = 12'h050,
  parameter logic [11:0] PROG_DEST  = 12'h200
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  flash_in,
  input  logic [PROG_SEL_W-1:0] prog_sel_in,
  output logic [LIB_ADDR_W-1:0] lib_addr_out,
  output logic                  lib_en_out,
  input  logic [7:0]            lib_data_in,
  output logic [11:0]           mem_addr_out,
  output logic [7:0]            mem_data_out,
  output logic                  mem_we_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out
);

  localparam logic [11:0] FontLast = 12'd79;
  localparam logic [15:0] LenMax   = 16'd3584;

  if (PROG_SEL_W != $clog2(NUM_PROGS)) begin : gen_sel_w_check
    $error("PROG_SEL_W must equal clog2(NUM_PROGS)");
  end

  typedef enum logic [2:0] {
    StIdle, StFont, StHdr, StLen, StCopy, StDrain, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [PROG_SEL_W-1:0] sel_q, sel_d;
  logic [11:0]           cnt_q, cnt_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic                  error_q, error_d;

  // Write-tag pipe, aligned with the 2-cycle library read latency.
  logic                  v1_q, v2_q;
  logic [11:0]           dest1_q, dest2_q;
  logic                  issue;
  logic [11:0]           issue_dest;

  logic [LIB_ADDR_W-1:0] base;
  assign base = LIB_ADDR_W'((32'(sel_q) + 32'd1) * SLOT_SIZE);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    len_hi_d     = len_hi_q;
    error_d      = error_q;
    issue        = 1'b0;
    issue_dest   = '0;
    lib_en_out   = 1'b0;
    lib_addr_out = '0;

    unique case (state_q)
      StIdle: begin
        if (flash_in) begin
          sel_d   = prog_sel_in;
          error_d = 1'b0;
          cnt_d   = '0;
          state_d = StFont;
        end
      end
      StFont: begin
        lib_en_out   = 1'b1;
        lib_addr_out = LIB_ADDR_W'(cnt_q);
        issue        = 1'b1;
        issue_dest   = FONT_DEST + cnt_q;
        if (cnt_q == FontLast) begin
          cnt_d   = '0;
          state_d = StHdr;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      StHdr: begin
        // Header reads are untagged; their data is picked up by cycle position in StLen.
        lib_en_out   = 1'b1;
        lib_addr_out = base + LIB_ADDR_W'(cnt_q);
        if (cnt_q == 12'd1) begin
          cnt_d   = '0;
          state_d = StLen;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      StLen: begin
        if (cnt_q == 12'd0) begin
          len_hi_d = lib_data_in;
          cnt_d    = 12'd1;
        end else begin
          cnt_d = '0;
          len_d = {len_hi_q, lib_data_in};
          if (len_d > LenMax) begin
            error_d = 1'b1;
            state_d = StDrain;
          end else if (len_d == 16'd0) begin
            state_d = StDrain;
          end else begin
            state_d = StCopy;
          end
        end
      end
      StCopy: begin
        lib_en_out   = 1'b1;
        lib_addr_out = base + LIB_ADDR_W'(cnt_q) + LIB_ADDR_W'(2);
        issue        = 1'b1;
        issue_dest   = PROG_DEST + cnt_q;
        if (16'(cnt_q) == len_q - 16'd1) begin
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      StDrain: begin
        if (!v1_q && !v2_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      len_hi_q <= '0;
      error_q  <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      dest1_q  <= '0;
      dest2_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      len_hi_q <= len_hi_d;
      error_q  <= error_d;
      v1_q     <= issue;
      v2_q     <= v1_q;
      dest1_q  <= issue_dest;
      dest2_q  <= dest1_q;
    end
  end

  assign mem_we_out   = v2_q;
  assign mem_addr_out = v2_q ? dest2_q : 12'h000;
  assign mem_data_out = v2_q ? lib_data_in : 8'h00;
  assign busy_out     = (state_q != StIdle) && (state_q != StDone);
  assign done_out     = (state_q == StDone);
  assign error_out    = error_q;

endmodule

// File: tb/tb_chip8_program_loader.sv
// Self-checking bench for chip8_program_loader: BRAM library model plus a queue-based model of
// the expected library read and memory write sequences.
module tb_chip8_program_loader;

  logic        clk;
  logic        rst;
  logic        flash;
  logic [2:0]  prog_sel;
  logic [15:0] lib_addr;
  logic        lib_en;
  logic [7:0]  lib_data;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        error;

  chip8_program_loader dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .flash_in    (flash),
    .prog_sel_in (prog_sel),
    .lib_addr_out(lib_addr),
    .lib_en_out  (lib_en),
    .lib_data_in (lib_data),
    .mem_addr_out(mem_addr),
    .mem_data_out(mem_data),
    .mem_we_out  (mem_we),
    .busy_out    (busy),
    .done_out    (done),
    .error_out   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Library ROM with 2-cycle read latency.
  logic [7:0] lib_mem [0:65535];
  logic [7:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= lib_en ? lib_mem[lib_addr] : 8'h00;
    rd2 <= rd1;
  end
  assign lib_data = rd2;

  int checks = 0;
  int errors = 0;

  logic [19:0] wr_q[$];
  logic [15:0] rd_q[$];
  bit          exp_err;
  int          done_cnt;
  int          wr_cnt;
  logic [11:0] cap_addr [0:4095];
  logic [7:0]  cap_data [0:4095];
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every write and every library read against the model queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we) begin
        if (wr_cnt < 4096) begin
          cap_addr[wr_cnt] = mem_addr;
          cap_data[wr_cnt] = mem_data;
        end
        wr_cnt++;
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_write: got %h/%h expected none", mem_addr, mem_data);
        end else begin
          chk("write_seq", 32'({mem_addr, mem_data}), 32'(wr_q.pop_front()));
        end
      end
      if (lib_en) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_read: got %h expected none", lib_addr);
        end else begin
          chk("read_seq", 32'(lib_addr), 32'(rd_q.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic set_prog(input int sel, input int len);
    int base;
    base = (sel + 1) * 4096;
    lib_mem[base]     = 8'(len >> 8);
    lib_mem[base + 1] = 8'(len);
    for (int i = 0; i < len && i < 3584; i++) lib_mem[base + 2 + i] = 8'($urandom);
  endtask

  task automatic push_model(input int sel);
    int base;
    int len;
    base = (sel + 1) * 4096;
    for (int i = 0; i < 80; i++) begin
      rd_q.push_back(16'(i));
      wr_q.push_back({12'(12'h050 + i), lib_mem[i]});
    end
    rd_q.push_back(16'(base));
    rd_q.push_back(16'(base + 1));
    len = {lib_mem[base], lib_mem[base + 1]};
    exp_err = (len > 3584);
    if (!exp_err) begin
      for (int i = 0; i < len; i++) begin
        rd_q.push_back(16'(base + 2 + i));
        wr_q.push_back({12'(12'h200 + i), lib_mem[base + 2 + i]});
      end
    end
  endtask

  task automatic pulse_flash(input int sel);
    @(posedge clk); #1;
    prog_sel = 3'(sel);
    flash    = 1'b1;
    @(posedge clk); #1;
    flash    = 1'b0;
  endtask

  task automatic do_load(input int sel, input bit lat, input bit probe, input bit mid);
    int cyc;
    push_model(sel);
    done_cnt = 0;
    wr_cnt   = 0;
    pulse_flash(sel);
    chk("error_cleared_on_accept", 32'(error), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    if (lat) begin
      chk("lat_c1_lib_en", 32'(lib_en), 32'd1);
      chk("lat_c1_lib_addr", 32'(lib_addr), 32'h0);
      chk("lat_c1_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      chk("lat_c2_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      chk("lat_c3_we", 32'(mem_we), 32'd1);
      chk("lat_c3_addr", 32'(mem_addr), 32'h050);
      chk("lat_c3_data", 32'(mem_data), 32'hF0);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 8000) begin
      if (mid && cyc == 120) begin
        prog_sel = 3'd3;
        flash    = 1'b1;
      end else begin
        flash = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    flash = 1'b0;
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 8000 cycles");
    end
    if (probe) begin
      flash = 1'b1;
      @(posedge clk); #1;
      flash = 1'b0;
      chk("flash_in_done_ignored", 32'({busy, lib_en}), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("error_out", 32'(error), 32'(exp_err));
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("writes_left", 32'(wr_q.size()), 32'd0);
    chk("reads_left", 32'(rd_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    int len;
    rst      = 1'b1;
    flash    = 1'b0;
    prog_sel = 3'd0;
    for (int i = 0; i < 65536; i++) lib_mem[i] = 8'($urandom);
    lib_mem[0] = 8'hF0; lib_mem[1] = 8'h90; lib_mem[2] = 8'h90;
    lib_mem[3] = 8'h90; lib_mem[4] = 8'hF0;
    #12;
    chk("rst_outputs", 32'({lib_addr, lib_en, mem_addr, mem_data, mem_we, busy, done, error}), 0);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Font only, with latency and DONE-cycle flash probe.
    set_prog(0, 0);
    do_load(0, 1'b1, 1'b1, 1'b0);
    chk("font_only_writes", 32'(wr_cnt), 32'd80);
    chk("font_last_addr", 32'(cap_addr[79]), 32'h09F);

    // Hand-built program in slot 3.
    lib_mem[3 * 4096]     = 8'h00;
    lib_mem[3 * 4096 + 1] = 8'h04;
    lib_mem[3 * 4096 + 2] = 8'hAA;
    lib_mem[3 * 4096 + 3] = 8'hBB;
    lib_mem[3 * 4096 + 4] = 8'hCC;
    lib_mem[3 * 4096 + 5] = 8'hDD;
    do_load(2, 1'b0, 1'b0, 1'b0);
    chk("prog4_writes", 32'(wr_cnt), 32'd84);
    chk("prog4_w80", 32'({cap_addr[80], cap_data[80]}), 32'h200AA);
    chk("prog4_w81", 32'({cap_addr[81], cap_data[81]}), 32'h201BB);
    chk("prog4_w82", 32'({cap_addr[82], cap_data[82]}), 32'h202CC);
    chk("prog4_w83", 32'({cap_addr[83], cap_data[83]}), 32'h203DD);

    // Random programs.
    for (int n = 0; n < 6; n++) begin
      sel = int'($urandom_range(0, 7));
      len = (n == 0) ? 1 : int'($urandom_range(0, 300));
      set_prog(sel, len);
      do_load(sel, 1'b0, 1'b0, 1'b0);
      chk("rand_writes", 32'(wr_cnt), 32'(80 + len));
    end

    // Largest legal program reaches the top of memory.
    set_prog(5, 3584);
    do_load(5, 1'b0, 1'b0, 1'b0);
    chk("max_writes", 32'(wr_cnt), 32'd3664);
    chk("max_last_addr", 32'(cap_addr[3663]), 32'hFFF);

    // Oversized program: font only, sticky error.
    set_prog(6, 3585);
    do_load(6, 1'b0, 1'b0, 1'b0);
    chk("ovf_writes", 32'(wr_cnt), 32'd80);
    chk("ovf_error_literal", 32'(error), 32'd1);

    // Next accepted flash clears the error.
    set_prog(1, 10);
    do_load(1, 1'b0, 1'b0, 1'b0);
    chk("clear_err_writes", 32'(wr_cnt), 32'd90);

    // flash_in mid-COPY is ignored.
    set_prog(4, 200);
    do_load(4, 1'b0, 1'b0, 1'b1);
    chk("busy_guard_writes", 32'(wr_cnt), 32'd280);

    // Asynchronous reset mid-COPY.
    set_prog(7, 300);
    push_model(7);
    done_cnt = 0;
    pulse_flash(7);
    repeat (150) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs",
        32'({lib_addr, lib_en, mem_addr, mem_data, mem_we, busy, done, error}), 0);
    wr_q.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_rst", 32'(done_cnt), 32'd0);
    chk("idle_after_rst", 32'(busy), 32'd0);
    do_load(7, 1'b0, 1'b0, 1'b0);
    chk("reload_writes", 32'(wr_cnt), 32'd380);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
